// File: rtl/v6502_pkg.sv
// Shared addressing-mode vocabulary: micro-op bit positions, sequencer states and
// the mode decode used by the address sequencer, prime decoder and execute stage.
package v6502_pkg;

    localparam int UOP_X   = 6;
    localparam int UOP_Y   = 5;
    localparam int UOP_ACC = 4;
    localparam int UOP_IMM = 3;
    localparam int UOP_ZP  = 2;
    localparam int UOP_ABS = 1;
    localparam int UOP_IND = 0;

    localparam logic [6:0] UOP_IMPLIED  = 7'b000_0000;
    localparam logic [6:0] UOP_ACC_ONLY = 7'b001_0000;
    localparam logic [6:0] UOP_IMM_ONLY = 7'b000_1000;
    localparam logic [6:0] UOP_ZP_ONLY  = 7'b000_0100;
    localparam logic [6:0] UOP_ZP_X     = 7'b100_0100;
    localparam logic [6:0] UOP_ABS_ONLY = 7'b000_0010;
    localparam logic [6:0] UOP_ABS_X    = 7'b100_0010;
    localparam logic [6:0] UOP_ABS_Y    = 7'b010_0010;
    localparam logic [6:0] UOP_IND_X    = 7'b100_0101;
    localparam logic [6:0] UOP_IND_Y    = 7'b010_0101;
    localparam logic [6:0] UOP_JMP_IND  = 7'b000_0011;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_OPR_LO = 3'd1,
        ST_OPR_HI = 3'd2,
        ST_PTR_LO = 3'd3,
        ST_PTR_HI = 3'd4,
        ST_INDEX  = 3'd5,
        ST_DONE   = 3'd6
    } seq_state_e;

    typedef enum logic [3:0] {
        MODE_IMPL = 4'd0,
        MODE_ACC  = 4'd1,
        MODE_IMM  = 4'd2,
        MODE_ZP   = 4'd3,
        MODE_ZPX  = 4'd4,
        MODE_ABS  = 4'd5,
        MODE_ABSX = 4'd6,
        MODE_ABSY = 4'd7,
        MODE_INDX = 4'd8,
        MODE_INDY = 4'd9,
        MODE_JIND = 4'd10
    } addr_mode_e;

    // Unlisted bit combinations fall back to implied addressing.
    function automatic addr_mode_e decode_mode(input logic [6:0] uop);
        addr_mode_e mode;
        case (uop)
            UOP_ACC_ONLY: mode = MODE_ACC;
            UOP_IMM_ONLY: mode = MODE_IMM;
            UOP_ZP_ONLY:  mode = MODE_ZP;
            UOP_ZP_X:     mode = MODE_ZPX;
            UOP_ABS_ONLY: mode = MODE_ABS;
            UOP_ABS_X:    mode = MODE_ABSX;
            UOP_ABS_Y:    mode = MODE_ABSY;
            UOP_IND_X:    mode = MODE_INDX;
            UOP_IND_Y:    mode = MODE_INDY;
            UOP_JMP_IND:  mode = MODE_JIND;
            default:      mode = MODE_IMPL;
        endcase
        return mode;
    endfunction

    function automatic logic [1:0] opr_bytes(input addr_mode_e mode);
        logic [1:0] n;
        case (mode)
            MODE_IMM, MODE_ZP, MODE_ZPX, MODE_INDX, MODE_INDY: n = 2'd1;
            MODE_ABS, MODE_ABSX, MODE_ABSY, MODE_JIND:        n = 2'd2;
            default:                                          n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/addr_sequencer_ea_adder.sv
// Index adder for effective-address formation: base + unsigned byte index, with an
// optional zero-page wrap that confines the result to page 0.
module ea_adder #(
    parameter int AW = 16,
    parameter int DW = 8
) (
    input  logic [AW-1:0] base,
    input  logic [DW-1:0] idx,
    input  logic          zp_wrap,
    output logic [AW-1:0] sum,
    output logic          page_cross
);

    logic [DW:0]      low_s;
    logic [AW-DW-1:0] high_s;

    // Split add so the low-byte carry is visible as the page-cross indication.
    always_comb begin
        low_s  = {1'b0, base[DW-1:0]} + {1'b0, idx};
        high_s = base[AW-1:DW] + {{(AW-DW-1){1'b0}}, low_s[DW]};
        if (zp_wrap) begin
            sum        = {{(AW-DW){1'b0}}, low_s[DW-1:0]};
            page_cross = 1'b0;
        end else begin
            sum        = {high_s, low_s[DW-1:0]};
            page_cross = low_s[DW];
        end
    end

endmodule

// File: rtl/addr_sequencer.sv
// Addressing-mode sequencer: fetches operand/pointer bytes and emits one effective address
// per accepted start. Define NMOS_JMP_BUG_EN to reproduce the JMP (ind) page-wrap quirk.
module addr_sequencer
    import v6502_pkg::*;
#(
    parameter int AW = 16,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [6:0]    addr_uop,
    input  logic [AW-1:0] pc_in,
    input  logic [DW-1:0] reg_x,
    input  logic [DW-1:0] reg_y,
    input  logic          flush,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          busy,
    output logic          ea_valid,
    output logic [AW-1:0] ea,
    output logic [AW-1:0] pc_next,
    output logic          page_cross,
    output logic          is_acc
);

    localparam logic [DW-1:0]    BYTE_ONE  = {{(DW-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0]    BYTE_ZERO = {DW{1'b0}};
    localparam logic [AW-1:0]    ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0]    ADDR_ZERO = {AW{1'b0}};
    localparam logic [AW-DW-1:0] ZP_PAGE   = {(AW-DW){1'b0}};

    seq_state_e    state_r;
    addr_mode_e    mode_r;
    addr_mode_e    start_mode_s;
    logic [AW-1:0] pc_r;
    logic [AW-1:0] ptr_r;
    logic [DW-1:0] x_r;
    logic [DW-1:0] y_r;
    logic [DW-1:0] lo_r;
    logic [DW-1:0] hi_r;

    logic          mem_req_r;
    logic [AW-1:0] mem_addr_r;
    logic          busy_r;
    logic          ea_valid_r;
    logic [AW-1:0] ea_r;
    logic [AW-1:0] pc_next_r;
    logic          page_cross_r;
    logic          is_acc_r;

    logic [AW-1:0] pc_next_s;
    logic [AW-1:0] ptr_hi_addr_s;
    logic [DW-1:0] zp_ptr_s;
    logic [AW-1:0] add_base_s;
    logic [DW-1:0] add_idx_s;
    logic          add_zp_s;
    logic [AW-1:0] add_sum_s;
    logic          add_pcx_s;

    // Next-address helpers and adder operand selection.
    always_comb begin
        start_mode_s = decode_mode(addr_uop);
        pc_next_s    = pc_r + {{(AW-2){1'b0}}, opr_bytes(mode_r)};
        zp_ptr_s     = mem_rdata + x_r;
`ifdef NMOS_JMP_BUG_EN
        ptr_hi_addr_s = {ptr_r[AW-1:DW], ptr_r[DW-1:0] + BYTE_ONE};
`else
        if (mode_r == MODE_JIND) begin
            ptr_hi_addr_s = ptr_r + ADDR_ONE;
        end else begin
            ptr_hi_addr_s = {ptr_r[AW-1:DW], ptr_r[DW-1:0] + BYTE_ONE};
        end
`endif
        // Zero-page modes add while the operand byte is on the bus; others add in INDEX.
        if (state_r == ST_OPR_LO) begin
            add_base_s = {ZP_PAGE, mem_rdata};
            add_idx_s  = (mode_r == MODE_ZPX) ? x_r : BYTE_ZERO;
            add_zp_s   = 1'b1;
        end else begin
            add_base_s = {hi_r, lo_r};
            add_idx_s  = (mode_r == MODE_ABSY || mode_r == MODE_INDY) ? y_r : x_r;
            add_zp_s   = 1'b0;
        end
    end

    ea_adder #(.AW(AW), .DW(DW)) u_ea_adder (
        .base       (add_base_s),
        .idx        (add_idx_s),
        .zp_wrap    (add_zp_s),
        .sum        (add_sum_s),
        .page_cross (add_pcx_s)
    );

    // Sequencer FSM with capture registers and registered bus/result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            mode_r       <= MODE_IMPL;
            pc_r         <= ADDR_ZERO;
            ptr_r        <= ADDR_ZERO;
            x_r          <= BYTE_ZERO;
            y_r          <= BYTE_ZERO;
            lo_r         <= BYTE_ZERO;
            hi_r         <= BYTE_ZERO;
            mem_req_r    <= 1'b0;
            mem_addr_r   <= ADDR_ZERO;
            busy_r       <= 1'b0;
            ea_valid_r   <= 1'b0;
            ea_r         <= ADDR_ZERO;
            pc_next_r    <= ADDR_ZERO;
            page_cross_r <= 1'b0;
            is_acc_r     <= 1'b0;
        end else if (flush) begin
            state_r    <= ST_IDLE;
            mem_req_r  <= 1'b0;
            busy_r     <= 1'b0;
            ea_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ea_valid_r <= 1'b0;
                    if (start) begin
                        mode_r <= start_mode_s;
                        pc_r   <= pc_in;
                        x_r    <= reg_x;
                        y_r    <= reg_y;
                        busy_r <= 1'b1;
                        case (start_mode_s)
                            MODE_IMPL, MODE_ACC, MODE_IMM: begin
                                state_r      <= ST_DONE;
                                ea_valid_r   <= 1'b1;
                                page_cross_r <= 1'b0;
                                is_acc_r     <= (start_mode_s == MODE_ACC);
                                ea_r         <= (start_mode_s == MODE_IMM) ? pc_in : ADDR_ZERO;
                                pc_next_r    <= (start_mode_s == MODE_IMM) ? pc_in + ADDR_ONE : pc_in;
                            end
                            default: begin
                                state_r    <= ST_OPR_LO;
                                mem_req_r  <= 1'b1;
                                mem_addr_r <= pc_in;
                            end
                        endcase
                    end
                end
                ST_OPR_LO: begin
                    if (mem_ack) begin
                        lo_r <= mem_rdata;
                        case (mode_r)
                            MODE_ZP, MODE_ZPX: begin
                                mem_req_r    <= 1'b0;
                                state_r      <= ST_DONE;
                                ea_valid_r   <= 1'b1;
                                ea_r         <= add_sum_s;
                                page_cross_r <= 1'b0;
                                is_acc_r     <= 1'b0;
                                pc_next_r    <= pc_next_s;
                            end
                            MODE_INDX: begin
                                state_r    <= ST_PTR_LO;
                                ptr_r      <= {ZP_PAGE, zp_ptr_s};
                                mem_addr_r <= {ZP_PAGE, zp_ptr_s};
                            end
                            MODE_INDY: begin
                                state_r    <= ST_PTR_LO;
                                ptr_r      <= {ZP_PAGE, mem_rdata};
                                mem_addr_r <= {ZP_PAGE, mem_rdata};
                            end
                            default: begin
                                state_r    <= ST_OPR_HI;
                                mem_addr_r <= pc_r + ADDR_ONE;
                            end
                        endcase
                    end
                end
                ST_OPR_HI: begin
                    if (mem_ack) begin
                        hi_r <= mem_rdata;
                        case (mode_r)
                            MODE_ABSX, MODE_ABSY: begin
                                mem_req_r <= 1'b0;
                                state_r   <= ST_INDEX;
                            end
                            MODE_JIND: begin
                                state_r    <= ST_PTR_LO;
                                ptr_r      <= {mem_rdata, lo_r};
                                mem_addr_r <= {mem_rdata, lo_r};
                            end
                            default: begin
                                mem_req_r    <= 1'b0;
                                state_r      <= ST_DONE;
                                ea_valid_r   <= 1'b1;
                                ea_r         <= {mem_rdata, lo_r};
                                page_cross_r <= 1'b0;
                                is_acc_r     <= 1'b0;
                                pc_next_r    <= pc_next_s;
                            end
                        endcase
                    end
                end
                ST_PTR_LO: begin
                    if (mem_ack) begin
                        lo_r       <= mem_rdata;
                        state_r    <= ST_PTR_HI;
                        mem_addr_r <= ptr_hi_addr_s;
                    end
                end
                ST_PTR_HI: begin
                    if (mem_ack) begin
                        hi_r      <= mem_rdata;
                        mem_req_r <= 1'b0;
                        if (mode_r == MODE_INDY) begin
                            state_r <= ST_INDEX;
                        end else begin
                            state_r      <= ST_DONE;
                            ea_valid_r   <= 1'b1;
                            ea_r         <= {mem_rdata, lo_r};
                            page_cross_r <= 1'b0;
                            is_acc_r     <= 1'b0;
                            pc_next_r    <= pc_next_s;
                        end
                    end
                end
                ST_INDEX: begin
                    state_r      <= ST_DONE;
                    ea_valid_r   <= 1'b1;
                    ea_r         <= add_sum_s;
                    page_cross_r <= add_pcx_s;
                    is_acc_r     <= 1'b0;
                    pc_next_r    <= pc_next_s;
                end
                ST_DONE: begin
                    state_r    <= ST_IDLE;
                    ea_valid_r <= 1'b0;
                    busy_r     <= 1'b0;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    mem_req_r  <= 1'b0;
                    busy_r     <= 1'b0;
                    ea_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req    = mem_req_r;
    assign mem_addr   = mem_addr_r;
    assign busy       = busy_r;
    assign ea_valid   = ea_valid_r;
    assign ea         = ea_r;
    assign pc_next    = pc_next_r;
    assign page_cross = page_cross_r;
    assign is_acc     = is_acc_r;

endmodule

// File: tb/tb_addr_sequencer.sv
// Self-checking bench for addr_sequencer: directed scenarios plus randomized instructions
// checked against an arithmetic reference model and a byte-array memory responder.
module tb_addr_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [6:0]  addr_uop;
    logic [15:0] pc_in;
    logic [7:0]  reg_x;
    logic [7:0]  reg_y;
    logic        flush;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic        busy;
    logic        ea_valid;
    logic [15:0] ea;
    logic [15:0] pc_next;
    logic        page_cross;
    logic        is_acc;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  mem [0:65535];
    logic [15:0] obs_addr_q [$];
    logic [15:0] exp_q [$];
    logic [15:0] exp_ea;
    logic [15:0] exp_pcn;
    bit          exp_pcx;
    bit          exp_acc;
    int          exp_idx;

    always #5 clk = ~clk;

    addr_sequencer #(.AW(16), .DW(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .addr_uop(addr_uop), .pc_in(pc_in),
        .reg_x(reg_x), .reg_y(reg_y), .flush(flush), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy), .ea_valid(ea_valid), .ea(ea),
        .pc_next(pc_next), .page_cross(page_cross), .is_acc(is_acc)
    );

    // Reference model: derives the bus read list and results from the addressing rules.
    task automatic ref_model(input logic [6:0] uop, input logic [15:0] pc, input logic [7:0] x, input logic [7:0] y);
        int lo, hi, ptr, ptr2, base, ix;
        exp_q.delete();
        exp_ea = 16'h0000; exp_pcn = pc; exp_pcx = 1'b0; exp_acc = 1'b0; exp_idx = 0;
        lo = int'(mem[pc]);
        hi = int'(mem[16'(int'(pc) + 1)]);
        ix = uop[6] ? int'(x) : (uop[5] ? int'(y) : 0);
        case (uop)
            7'b0010000: exp_acc = 1'b1;
            7'b0001000: begin exp_ea = pc; exp_pcn = 16'(int'(pc) + 1); end
            7'b0000100, 7'b1000100: begin
                exp_q.push_back(pc);
                exp_pcn = 16'(int'(pc) + 1);
                exp_ea = 16'((lo + ix) % 256);
            end
            7'b0000010, 7'b1000010, 7'b0100010: begin
                exp_q.push_back(pc); exp_q.push_back(16'(int'(pc) + 1));
                exp_pcn = 16'(int'(pc) + 2);
                base = hi * 256 + lo;
                exp_ea = 16'(base + ix);
                exp_pcx = (lo + ix) > 255;
                exp_idx = (uop != 7'b0000010) ? 1 : 0;
            end
            7'b1000101: begin
                ptr = (lo + ix) % 256; ptr2 = (ptr + 1) % 256;
                exp_q.push_back(pc); exp_q.push_back(16'(ptr)); exp_q.push_back(16'(ptr2));
                exp_pcn = 16'(int'(pc) + 1);
                exp_ea = 16'(int'(mem[16'(ptr2)]) * 256 + int'(mem[16'(ptr)]));
            end
            7'b0100101: begin
                ptr = lo; ptr2 = (lo + 1) % 256;
                exp_q.push_back(pc); exp_q.push_back(16'(ptr)); exp_q.push_back(16'(ptr2));
                exp_pcn = 16'(int'(pc) + 1);
                base = int'(mem[16'(ptr2)]) * 256 + int'(mem[16'(ptr)]);
                exp_ea = 16'(base + ix);
                exp_pcx = (int'(mem[16'(ptr)]) + ix) > 255;
                exp_idx = 1;
            end
            7'b0000011: begin
                ptr = hi * 256 + lo;
`ifdef NMOS_JMP_BUG_EN
                ptr2 = (ptr / 256) * 256 + ((ptr + 1) % 256);
`else
                ptr2 = (ptr + 1) % 65536;
`endif
                exp_q.push_back(pc); exp_q.push_back(16'(int'(pc) + 1));
                exp_q.push_back(16'(ptr)); exp_q.push_back(16'(ptr2));
                exp_pcn = 16'(int'(pc) + 2);
                exp_ea = 16'(int'(mem[16'(ptr2)]) * 256 + int'(mem[16'(ptr)]));
            end
            default: ;
        endcase
    endtask

    // Drives one instruction and answers its reads; dly < 0 picks random ack delays.
    task automatic exec_instr(input logic [6:0] uop, input logic [15:0] pc, input logic [7:0] x,
                              input logic [7:0] y, input int dly, input bit spam,
                              output bit got, output int lat, output int dsum,
                              output bit stable_ok, output bit busy_ok, output bit pulse_ok);
        int wait_left;
        logic [15:0] held;
        bit in_req;
        obs_addr_q.delete();
        got = 1'b0; lat = 0; dsum = 0; stable_ok = 1'b1; busy_ok = 1'b1; pulse_ok = 1'b1;
        in_req = 1'b0; wait_left = 0; held = 16'h0000;
        start = 1'b1; addr_uop = uop; pc_in = pc; reg_x = x; reg_y = y;
        @(posedge clk); #1;
        if (spam) begin
            addr_uop = 7'($urandom); pc_in = 16'($urandom); reg_x = 8'($urandom); reg_y = 8'($urandom);
        end else begin
            start = 1'b0;
        end
        for (int cnt = 1; cnt <= 200 && !got; cnt++) begin
            @(negedge clk);
            mem_ack = 1'b0; mem_rdata = 8'($urandom);
            if (!busy) busy_ok = 1'b0;
            if (ea_valid) begin
                got = 1'b1; lat = cnt;
            end else if (mem_req) begin
                if (!in_req) begin
                    in_req = 1'b1; held = mem_addr; obs_addr_q.push_back(mem_addr);
                    wait_left = (dly < 0) ? $urandom_range(0, 3) : dly;
                    dsum += wait_left;
                end else if (mem_addr !== held) begin
                    stable_ok = 1'b0;
                end
                if (wait_left == 0) begin
                    mem_ack = 1'b1; mem_rdata = mem[mem_addr]; in_req = 1'b0;
                end else begin
                    wait_left--;
                end
            end else if (in_req) begin
                stable_ok = 1'b0; in_req = 1'b0;
            end
        end
        @(negedge clk);
        mem_ack = 1'b0;
        if (ea_valid || busy || mem_req) pulse_ok = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({mem_req, busy, ea_valid, page_cross, is_acc, ea, pc_next, mem_addr} !== 53'd0)
            $display("FAIL reset_outputs got req=%b busy=%b v=%b pcx=%b acc=%b ea=%h pcn=%h addr=%h want all 0",
                     mem_req, busy, ea_valid, page_cross, is_acc, ea, pc_next, mem_addr);
        else n_pass++;
    endtask

    task automatic test_zpx();
        bit got, s_ok, b_ok, p_ok; int lat, dsum;
        mem[16'h0200] = 8'hFF;
        exec_instr(7'b1000100, 16'h0200, 8'h02, 8'h00, 0, 1'b0, got, lat, dsum, s_ok, b_ok, p_ok);
        n_checks++; if (!got || lat != 2) $display("FAIL zpx_latency got=%0d valid=%b want=2", lat, got); else n_pass++;
        n_checks++; if (ea !== 16'h0001) $display("FAIL zpx_ea got=%h want=0001", ea); else n_pass++;
        n_checks++; if (pc_next !== 16'h0201) $display("FAIL zpx_pc_next got=%h want=0201", pc_next); else n_pass++;
        n_checks++; if (page_cross !== 1'b0) $display("FAIL zpx_page_cross got=%b want=0", page_cross); else n_pass++;
    endtask

    task automatic test_absy();
        bit got, s_ok, b_ok, p_ok; int lat, dsum;
        mem[16'h0300] = 8'h80; mem[16'h0301] = 8'h12;
        exec_instr(7'b0100010, 16'h0300, 8'h00, 8'h90, 0, 1'b0, got, lat, dsum, s_ok, b_ok, p_ok);
        n_checks++; if (!got || lat != 4) $display("FAIL absy_latency got=%0d valid=%b want=4", lat, got); else n_pass++;
        n_checks++; if (ea !== 16'h1310) $display("FAIL absy_ea got=%h want=1310", ea); else n_pass++;
        n_checks++; if (page_cross !== 1'b1) $display("FAIL absy_page_cross got=%b want=1", page_cross); else n_pass++;
        n_checks++; if (pc_next !== 16'h0302) $display("FAIL absy_pc_next got=%h want=0302", pc_next); else n_pass++;
    endtask

    task automatic test_indy();
        bit got, s_ok, b_ok, p_ok; int lat, dsum;
        mem[16'h0400] = 8'hFF; mem[16'h00FF] = 8'h34; mem[16'h0000] = 8'h12;
        exec_instr(7'b0100101, 16'h0400, 8'h00, 8'h01, 0, 1'b0, got, lat, dsum, s_ok, b_ok, p_ok);
        n_checks++;
        if (obs_addr_q.size() != 3 || obs_addr_q[1] !== 16'h00FF || obs_addr_q[2] !== 16'h0000)
            $display("FAIL indy_ptr_reads got n=%0d %p want 0400,00FF,0000", obs_addr_q.size(), obs_addr_q);
        else n_pass++;
        n_checks++; if (ea !== 16'h1235) $display("FAIL indy_ea got=%h want=1235", ea); else n_pass++;
        n_checks++; if (!got || lat != 5) $display("FAIL indy_latency got=%0d valid=%b want=5", lat, got); else n_pass++;
    endtask

    task automatic test_jmp_ind();
        bit got, s_ok, b_ok, p_ok; int lat, dsum;
        logic [15:0] want_hi_addr, want_ea;
        mem[16'h0500] = 8'hFF; mem[16'h0501] = 8'h10;
        mem[16'h10FF] = 8'hCD; mem[16'h1000] = 8'hAB; mem[16'h1100] = 8'hEF;
`ifdef NMOS_JMP_BUG_EN
        want_hi_addr = 16'h1000; want_ea = 16'hABCD;
`else
        want_hi_addr = 16'h1100; want_ea = 16'hEFCD;
`endif
        exec_instr(7'b0000011, 16'h0500, 8'h00, 8'h00, 0, 1'b0, got, lat, dsum, s_ok, b_ok, p_ok);
        n_checks++;
        if (obs_addr_q.size() != 4 || obs_addr_q[2] !== 16'h10FF || obs_addr_q[3] !== want_hi_addr)
            $display("FAIL jmp_ptr_reads got n=%0d %p want ptr 10FF then %h", obs_addr_q.size(), obs_addr_q, want_hi_addr);
        else n_pass++;
        n_checks++; if (ea !== want_ea) $display("FAIL jmp_ea got=%h want=%h", ea, want_ea); else n_pass++;
        n_checks++; if (pc_next !== 16'h0502) $display("FAIL jmp_pc_next got=%h want=0502", pc_next); else n_pass++;
    endtask

    task automatic test_handshake();
        bit got, s_ok, b_ok, p_ok; int lat, dsum;
        mem[16'h0700] = 8'hF0; mem[16'h0701] = 8'h22;
        exec_instr(7'b1000010, 16'h0700, 8'h20, 8'h00, 3, 1'b1, got, lat, dsum, s_ok, b_ok, p_ok);
        n_checks++; if (s_ok !== 1'b1) $display("FAIL hs_req_stable got=%b want=1", s_ok); else n_pass++;
        n_checks++; if (!got || lat != 10) $display("FAIL hs_latency got=%0d valid=%b want=10", lat, got); else n_pass++;
        n_checks++; if (ea !== 16'h2310 || page_cross !== 1'b1) $display("FAIL hs_ea got=%h/%b want=2310/1", ea, page_cross); else n_pass++;
        n_checks++; if (p_ok !== 1'b1 || b_ok !== 1'b1) $display("FAIL hs_busy_pulse got=%b/%b want=1/1", b_ok, p_ok); else n_pass++;
        exec_instr(7'b0010000, 16'h0900, 8'h00, 8'h00, 0, 1'b0, got, lat, dsum, s_ok, b_ok, p_ok);
        n_checks++;
        if (!got || lat != 1 || is_acc !== 1'b1 || ea !== 16'h0000 || pc_next !== 16'h0900)
            $display("FAIL acc_result got lat=%0d acc=%b ea=%h pcn=%h want 1/1/0000/0900", lat, is_acc, ea, pc_next);
        else n_pass++;
        exec_instr(7'b0001000, 16'h1234, 8'h00, 8'h00, 0, 1'b0, got, lat, dsum, s_ok, b_ok, p_ok);
        n_checks++;
        if (!got || lat != 1 || ea !== 16'h1234 || pc_next !== 16'h1235 || is_acc !== 1'b0)
            $display("FAIL imm_result got lat=%0d ea=%h pcn=%h acc=%b want 1/1234/1235/0", lat, ea, pc_next, is_acc);
        else n_pass++;
    endtask

    task automatic test_flush();
        bit saw_valid;
        mem[16'h0600] = 8'h11; mem[16'h0601] = 8'h22;
        start = 1'b1; addr_uop = 7'b0000010; pc_in = 16'h0600;
        @(negedge clk);
        start = 1'b0; mem_ack = 1'b1; mem_rdata = mem[16'h0600];
        @(negedge clk);
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0601) $display("FAIL flush_opr_hi got req=%b addr=%h want 1/0601", mem_req, mem_addr); else n_pass++;
        mem_ack = 1'b1; mem_rdata = mem[16'h0601]; flush = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0; flush = 1'b0;
        n_checks++; if ({mem_req, busy, ea_valid} !== 3'b000) $display("FAIL flush_idle got req/busy/v=%b%b%b want 000", mem_req, busy, ea_valid); else n_pass++;
        saw_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ea_valid || busy) saw_valid = 1'b1;
        end
        n_checks++; if (saw_valid || ea !== 16'h1234) $display("FAIL flush_no_result got late=%b ea=%h want 0/1234", saw_valid, ea); else n_pass++;
        start = 1'b1; flush = 1'b1; addr_uop = 7'b0001000; pc_in = 16'h4444;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        n_checks++; if ({busy, ea_valid, mem_req} !== 3'b000 || ea !== 16'h1234) $display("FAIL flush_start_drop got busy/v/req=%b%b%b ea=%h want 000/1234", busy, ea_valid, mem_req, ea); else n_pass++;
    endtask

    task automatic test_random();
        logic [6:0] tbl [11] = '{7'b0000000, 7'b0010000, 7'b0001000, 7'b0000100, 7'b1000100,
                                 7'b0000010, 7'b1000010, 7'b0100010, 7'b1000101, 7'b0100101, 7'b0000011};
        for (int i = 0; i < 40; i++) begin
            logic [6:0] uop; logic [15:0] pc; logic [7:0] x, y;
            bit got, s_ok, b_ok, p_ok; int lat, dsum;
            uop = ($urandom_range(0, 9) == 0) ? 7'($urandom) : tbl[$urandom_range(0, 10)];
            pc = 16'($urandom); x = 8'($urandom); y = 8'($urandom);
            if ($urandom_range(0, 3) == 0) mem[pc] = 8'hFF;
            ref_model(uop, pc, x, y);
            exec_instr(uop, pc, x, y, -1, 1'($urandom_range(0, 1)), got, lat, dsum, s_ok, b_ok, p_ok);
            n_checks++; if (!got || lat != exp_q.size() + dsum + exp_idx + 1)
                $display("FAIL rnd_latency uop=%b got=%0d valid=%b want=%0d", uop, lat, got, exp_q.size() + dsum + exp_idx + 1); else n_pass++;
            n_checks++; if (ea !== exp_ea) $display("FAIL rnd_ea uop=%b got=%h want=%h", uop, ea, exp_ea); else n_pass++;
            n_checks++; if (pc_next !== exp_pcn) $display("FAIL rnd_pc_next uop=%b got=%h want=%h", uop, pc_next, exp_pcn); else n_pass++;
            n_checks++; if ({page_cross, is_acc} !== {exp_pcx, exp_acc}) $display("FAIL rnd_flags uop=%b got=%b%b want=%b%b", uop, page_cross, is_acc, exp_pcx, exp_acc); else n_pass++;
            n_checks++; if (obs_addr_q.size() != exp_q.size()) $display("FAIL rnd_read_count uop=%b got=%0d want=%0d", uop, obs_addr_q.size(), exp_q.size()); else n_pass++;
            for (int k = 0; k < exp_q.size() && k < obs_addr_q.size(); k++) begin
                n_checks++; if (obs_addr_q[k] !== exp_q[k]) $display("FAIL rnd_read_addr uop=%b idx=%0d got=%h want=%h", uop, k, obs_addr_q[k], exp_q[k]); else n_pass++;
            end
            n_checks++; if ({s_ok, b_ok, p_ok} !== 3'b111) $display("FAIL rnd_handshake uop=%b got stable/busy/pulse=%b%b%b want 111", uop, s_ok, b_ok, p_ok); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        mem[16'h0800] = 8'h40;
        start = 1'b1; addr_uop = 7'b0100101; pc_in = 16'h0800; reg_y = 8'h05;
        @(negedge clk);
        start = 1'b0; mem_ack = 1'b1; mem_rdata = mem[16'h0800];
        @(negedge clk);
        mem_ack = 1'b0;
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0040) $display("FAIL rstmid_ptr_lo got req=%b addr=%h want 1/0040", mem_req, mem_addr); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++; if ({mem_req, busy, ea_valid} !== 3'b000 || ea !== 16'h0000) $display("FAIL rstmid_async got req/busy/v=%b%b%b ea=%h want 000/0000", mem_req, busy, ea_valid, ea); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if ({mem_req, busy} !== 2'b00) $display("FAIL rstmid_after got req/busy=%b%b want 00", mem_req, busy); else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; addr_uop = 7'd0; pc_in = 16'h0000; reg_x = 8'h00; reg_y = 8'h00;
        flush = 1'b0; mem_rdata = 8'h00; mem_ack = 1'b0;
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_zpx();
        test_absy();
        test_indy();
        test_jmp_ind();
        test_handshake();
        test_flush();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
